// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: control states, opcodes, ALU source selects.
// Zero-valued selects (PC, CONST4) double as the reset/idle datapath setting.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    ADDR      = 4'd4,
    MEM_RD    = 4'd5,
    MEM_WR    = 4'd6,
    BRANCH    = 4'd7,
    WRITEBACK = 4'd8,
    TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic       SRC_A_PC     = 1'b0;
  localparam logic       SRC_A_REGOUT = 1'b1;
  localparam logic [1:0] SRC_B_CONST4 = 2'd0;
  localparam logic [1:0] SRC_B_REGOUT = 2'd1;
  localparam logic [1:0] SRC_B_SIGEXT = 2'd2;

  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts not-ready cycles, saturating at MEM_TIMEOUT.
// expired is combinational from the count; clear has priority over counting.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic ready,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!ready && (cnt != 8'(MEM_TIMEOUT))) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM with memory-wait timeout and sticky illegal/timeout traps.
// Strobes are Moore-decoded from state except IRWrite (mem_ready) and PCWrite in BRANCH (zero).
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH    = 7,
  parameter int unsigned ALU_SRC_B_WIDTH = 2,
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter int unsigned EN_BRANCH       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [OPCODE_WIDTH-1:0]    opCode,
  input  logic                       mem_ready,
  input  logic                       zero,
  output logic                       PCWrite,
  output logic                       PCWriteCond,
  output logic                       IRWrite,
  output logic                       regFileWrite,
  output logic                       ALUOverride,
  output logic                       memRead,
  output logic                       memWrite,
  output logic                       memToReg,
  output logic                       ALUSrcA,
  output logic [ALU_SRC_B_WIDTH-1:0] ALUSrcB,
  output logic                       illegal,
  output logic                       timeout_err,
  output logic [3:0]                 state_out
);

  state_t state, state_nxt;
  logic   m2r_q, illegal_q, timeout_q;
  logic   set_illegal, set_timeout, expired;
  logic   pcw, pcwc, irw, rfw, alu_ovr, mrd, mwr;
  logic                       sel_a, sel_a_q;
  logic [ALU_SRC_B_WIDTH-1:0] sel_b, sel_b_q;

  // Counter restarts only when a wait state is newly entered, not while resident.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (is_wait_state(state_nxt) && (state_nxt != state)),
    .ready   (mem_ready || !is_wait_state(state)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      m2r_q     <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      sel_a_q   <= SRC_A_PC;
      sel_b_q   <= ALU_SRC_B_WIDTH'(SRC_B_CONST4);
    end else begin
      state   <= state_nxt;
      sel_a_q <= sel_a;
      sel_b_q <= sel_b;
      if (state == MEM_RD)     m2r_q <= 1'b1;
      else if (state == FETCH) m2r_q <= 1'b0;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    pcw = 1'b0; pcwc = 1'b0; irw = 1'b0; rfw = 1'b0;
    alu_ovr = 1'b0; mrd = 1'b0; mwr = 1'b0;
    sel_a = sel_a_q;
    sel_b = sel_b_q;
    case (state)
      FETCH: begin
        mrd = 1'b1; alu_ovr = 1'b1; irw = mem_ready;
        sel_a = SRC_A_PC; sel_b = ALU_SRC_B_WIDTH'(SRC_B_CONST4);
        if (mem_ready) state_nxt = DECODE;
        else if (expired) begin state_nxt = TRAP; set_timeout = 1'b1; end
      end
      DECODE: begin
        pcw = 1'b1;
        if (opCode == OPCODE_WIDTH'(OP_RTYPE))       state_nxt = EXEC_R;
        else if (opCode == OPCODE_WIDTH'(OP_ITYPE))  state_nxt = EXEC_I;
        else if (opCode == OPCODE_WIDTH'(OP_LOAD) || opCode == OPCODE_WIDTH'(OP_STORE))
          state_nxt = ADDR;
        else if (EN_BRANCH != 0 && opCode == OPCODE_WIDTH'(OP_BRANCH)) state_nxt = BRANCH;
        else begin state_nxt = TRAP; set_illegal = 1'b1; end
      end
      EXEC_R: begin
        sel_a = SRC_A_REGOUT; sel_b = ALU_SRC_B_WIDTH'(SRC_B_REGOUT);
        state_nxt = WRITEBACK;
      end
      EXEC_I: begin
        sel_a = SRC_A_REGOUT; sel_b = ALU_SRC_B_WIDTH'(SRC_B_SIGEXT);
        state_nxt = WRITEBACK;
      end
      ADDR: begin
        sel_a = SRC_A_REGOUT; sel_b = ALU_SRC_B_WIDTH'(SRC_B_SIGEXT);
        if (opCode == OPCODE_WIDTH'(OP_LOAD))       state_nxt = MEM_RD;
        else if (opCode == OPCODE_WIDTH'(OP_STORE)) state_nxt = MEM_WR;
        else begin state_nxt = TRAP; set_illegal = 1'b1; end
      end
      MEM_RD: begin
        mrd = 1'b1;
        if (mem_ready) state_nxt = WRITEBACK;
        else if (expired) begin state_nxt = TRAP; set_timeout = 1'b1; end
      end
      MEM_WR: begin
        mwr = 1'b1;
        if (mem_ready) state_nxt = FETCH;
        else if (expired) begin state_nxt = TRAP; set_timeout = 1'b1; end
      end
      BRANCH: begin
        pcwc = 1'b1; pcw = zero;
        sel_a = SRC_A_REGOUT; sel_b = ALU_SRC_B_WIDTH'(SRC_B_REGOUT);
        state_nxt = FETCH;
      end
      WRITEBACK: begin
        rfw = 1'b1;
        state_nxt = FETCH;
      end
      TRAP: state_nxt = TRAP;
      default: begin state_nxt = TRAP; set_illegal = 1'b1; end
    endcase
  end

  // Reset gates the decode so FETCH strobes never leak while rst_n is low.
  assign PCWrite      = rst_n & pcw;
  assign PCWriteCond  = rst_n & pcwc;
  assign IRWrite      = rst_n & irw;
  assign regFileWrite = rst_n & rfw;
  assign ALUOverride  = rst_n & alu_ovr;
  assign memRead      = rst_n & mrd;
  assign memWrite     = rst_n & mwr;
  assign memToReg     = rst_n & m2r_q & (state == WRITEBACK);
  assign ALUSrcA      = rst_n & sel_a;
  assign ALUSrcB      = rst_n ? sel_b : '0;
  assign illegal      = illegal_q;
  assign timeout_err  = timeout_q;
  assign state_out    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction paths, memory waits, traps and reset.
// A second instance with the branch path disabled shares the stimulus.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n, mem_ready, zero;
  logic [6:0] opCode;

  logic       PCWrite, PCWriteCond, IRWrite, regFileWrite, ALUOverride;
  logic       memRead, memWrite, memToReg, ALUSrcA, illegal, timeout_err;
  logic [1:0] ALUSrcB;
  logic [3:0] state_out;

  logic       nb_PCWrite, nb_PCWriteCond, nb_IRWrite, nb_regFileWrite, nb_ALUOverride;
  logic       nb_memRead, nb_memWrite, nb_memToReg, nb_ALUSrcA, nb_illegal, nb_timeout_err;
  logic [1:0] nb_ALUSrcB;
  logic [3:0] nb_state_out;

  int n_cmp = 0;
  int n_err = 0;
  int rfw_cnt = 0;
  int n;

  logic [7:0] strb, nb_strb;
  assign strb    = {PCWrite, PCWriteCond, IRWrite, regFileWrite,
                    ALUOverride, memRead, memWrite, memToReg};
  assign nb_strb = {nb_PCWrite, nb_PCWriteCond, nb_IRWrite, nb_regFileWrite,
                    nb_ALUOverride, nb_memRead, nb_memWrite, nb_memToReg};

  always #5 clk = ~clk;

  multicycle_controller #(.OPCODE_WIDTH(7), .ALU_SRC_B_WIDTH(2), .MEM_TIMEOUT(15), .EN_BRANCH(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .regFileWrite(regFileWrite), .ALUOverride(ALUOverride), .memRead(memRead),
    .memWrite(memWrite), .memToReg(memToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .illegal(illegal), .timeout_err(timeout_err), .state_out(state_out)
  );

  multicycle_controller #(.OPCODE_WIDTH(7), .ALU_SRC_B_WIDTH(2), .MEM_TIMEOUT(15), .EN_BRANCH(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(nb_PCWrite), .PCWriteCond(nb_PCWriteCond), .IRWrite(nb_IRWrite),
    .regFileWrite(nb_regFileWrite), .ALUOverride(nb_ALUOverride), .memRead(nb_memRead),
    .memWrite(nb_memWrite), .memToReg(nb_memToReg), .ALUSrcA(nb_ALUSrcA), .ALUSrcB(nb_ALUSrcB),
    .illegal(nb_illegal), .timeout_err(nb_timeout_err), .state_out(nb_state_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    if (regFileWrite) rfw_cnt++;
  endtask

  task automatic tick();
    step();
    settle();
  endtask

  task automatic release_reset(input logic rdy, input logic [6:0] op);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = rdy; opCode = op;
    settle();
  endtask

  initial begin
    rst_n = 1'b0; opCode = '0; mem_ready = 1'b0; zero = 1'b0;
    #2;
    // strobe vector bits: PCWrite PCWriteCond IRWrite regFileWrite ALUOverride memRead memWrite memToReg
    check("rst_strobes", 32'(strb), 0);
    check("rst_selects", 32'({ALUSrcA, ALUSrcB}), 0);
    check("rst_state", 32'(state_out), 0);
    check("rst_flags", 32'({illegal, timeout_err}), 0);
    repeat (2) @(posedge clk);

    // R-type, memory always ready
    release_reset(1'b1, OP_R);
    rfw_cnt = 0;
    check("r_fetch_state", 32'(state_out), 0);
    check("r_fetch_strb", 32'(strb), 32'h2C);
    tick(); check("r_decode_state", 32'(state_out), 1);
    check("r_decode_strb", 32'(strb), 32'h80);
    tick(); check("r_exec_state", 32'(state_out), 2);
    check("r_exec_strb", 32'(strb), 0);
    check("r_exec_sel", 32'({ALUSrcA, ALUSrcB}), 32'b101);
    tick(); check("r_wb_state", 32'(state_out), 8);
    check("r_wb_strb", 32'(strb), 32'h10);
    tick(); check("r_back_fetch", 32'(state_out), 0);
    check("r_rfw_cycles", 32'(rfw_cnt), 1);

    // load with three not-ready cycles in MEM_RD
    opCode = OP_LD;
    tick(); check("ld_decode_state", 32'(state_out), 1);
    tick(); check("ld_addr_state", 32'(state_out), 4);
    check("ld_addr_sel", 32'({ALUSrcA, ALUSrcB}), 32'b110);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); mem_ready = (i == 3); settle();
      check("ld_memrd_state", 32'(state_out), 5);
      check("ld_memrd_strb", 32'(strb), 32'h04);
    end
    tick(); check("ld_wb_state", 32'(state_out), 8);
    check("ld_wb_strb", 32'(strb), 32'h11);
    tick(); check("ld_fetch_strb", 32'(strb), 32'h2C);

    // store with two not-ready cycles in MEM_WR
    opCode = OP_ST; rfw_cnt = 0;
    tick(); tick(); check("st_addr_state", 32'(state_out), 4);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); mem_ready = (i == 2); settle();
      check("st_memwr_state", 32'(state_out), 6);
      check("st_memwr_strb", 32'(strb), 32'h02);
    end
    tick(); check("st_back_fetch", 32'(state_out), 0);
    check("st_no_rfw", 32'(rfw_cnt), 0);

    // branch taken then not taken; branch-disabled instance traps
    opCode = OP_BR; zero = 1'b1;
    tick(); check("br1_decode_state", 32'(state_out), 1);
    tick(); check("br1_state", 32'(state_out), 7);
    check("br1_strb", 32'(strb), 32'hC0);
    check("br1_sel", 32'({ALUSrcA, ALUSrcB}), 32'b101);
    check("nb_trap_state", 32'(nb_state_out), 9);
    check("nb_illegal", 32'(nb_illegal), 1);
    check("nb_trap_strb", 32'(nb_strb), 0);
    tick(); check("br1_fetch", 32'(state_out), 0);
    zero = 1'b0;
    tick(); tick(); check("br0_state", 32'(state_out), 7);
    check("br0_strb", 32'(strb), 32'h40);
    tick(); check("br0_fetch", 32'(state_out), 0);

    // unknown opcode traps on main instance
    opCode = 7'h7F;
    tick(); tick(); check("ill_state", 32'(state_out), 9);
    check("ill_flags", 32'({illegal, timeout_err}), 32'b10);
    check("ill_strb", 32'(strb), 0);
    tick(); check("ill_stays", 32'(state_out), 9);

    // reset pulsed during MEM_WR
    rst_n = 1'b0; #1;
    check("rst_clears_illegal", 32'(illegal), 0);
    repeat (2) @(posedge clk);
    release_reset(1'b1, OP_ST);
    tick(); tick(); mem_ready = 1'b0;
    tick(); check("mw_state", 32'(state_out), 6);
    check("mw_write", 32'(memWrite), 1);
    rst_n = 1'b0; #1;
    check("mw_rst_strb", 32'(strb), 0);
    check("mw_rst_state", 32'(state_out), 0);
    step(); check("mw_rst_hold_strb", 32'(strb), 0);
    release_reset(1'b1, OP_R);
    check("mw_rel_fetch", 32'(state_out), 0);
    tick(); check("mw_rel_decode", 32'(state_out), 1);

    // memory stuck not-ready in FETCH
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset(1'b0, OP_R);
    n = 0;
    while (state_out == 4'd0 && n < 40) begin
      n++;
      tick();
    end
    check("to_fetch_cycles", 32'(n), 16);
    check("to_state", 32'(state_out), 9);
    check("to_flags", 32'({illegal, timeout_err}), 32'b01);
    check("to_strb", 32'(strb), 0);
    repeat (3) tick();
    check("to_sticky", 32'({state_out, timeout_err}), 32'b10011);
    rst_n = 1'b0; #1;
    check("to_rst_clear", 32'({state_out, timeout_err}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
